axi4lite_req_master: RTL and testbench
======================================

AXI4LITE_REQ_MASTER -- requirements
Module: axi4lite_req_master

Interface
REQ-001 clk  input  1  clock; all logic on the rising edge.
REQ-002 rstn  input  1  reset: synchronous, active-low.
REQ-003 req_valid / req_ready  input / output  1 / 1  client request handshake.
REQ-004 req_write  input  1  1 = write, 0 = read.
REQ-005 req_addr / req_wdata / req_wstrb  input  `AXI4_ADDR_BITS / `AXI4_DATA_BITS / `AXI4_STRB_BITS  request payload.
REQ-006 rsp_valid / rsp_ready  output / input  1 / 1  client response handshake.
REQ-007 rsp_write / rsp_rdata / rsp_resp  output  1 / `AXI4_DATA_BITS / `AXI4_RESP_BITS  response kind, read data and AXI response.
REQ-008 m_axi4lite_aw_* (valid, ready, addr, prot), w_* (valid, ready, data, strb), b_* (valid, ready, resp), ar_* (valid, ready, addr, prot) and r_* (valid, ready, data, resp) SHALL be AXI4-Lite manager-side ports, with widths taken from the `AXI4_*_BITS macros.

Function
REQ-009 The block SHALL have exactly one outstanding transaction, tracked by states IDLE, WRITE, WRESP, READ, RRESP, DONE.
REQ-010 req_ready SHALL be 1 only in IDLE. A request fire SHALL register addr, wdata, wstrb and write, then go to WRITE (write=1) or READ (write=0).
REQ-011 In WRITE, aw_valid and w_valid SHALL be asserted from the first WRITE cycle.
- Each valid SHALL drop the cycle after its own fire.
- The two channel acceptances SHALL be tracked independently, in either order or in the same cycle.
REQ-012 WRITE SHALL go to WRESP in the cycle after both AW and W have fired.
REQ-013 In WRESP, b_ready SHALL be 1. A b fire SHALL capture b_resp, set rsp_write=1, set rsp_rdata=0, and go to DONE.
REQ-014 In READ, ar_valid SHALL be 1. An ar fire SHALL go to RRESP.
REQ-015 In RRESP, r_ready SHALL be 1. An r fire SHALL capture r_data and r_resp, set rsp_write=0, and go to DONE.
REQ-016 In DONE, rsp_valid SHALL be 1 and the response outputs SHALL be held stable. An rsp fire SHALL go to IDLE.
REQ-017 aw_prot and ar_prot SHALL be 3'b000. AXI addr, data and strb SHALL be driven from the registered request and SHALL be stable while valid.
REQ-018 No valid SHALL be withdrawn before its ready.
REQ-019 Minimum latency, with zero-wait subordinate and client, SHALL be as follows.
- Request fire at cycle 0.
- aw/w/ar valid at cycle 1.
- b/r fire at cycle 2.
- rsp_valid at cycle 3.
- Next req_ready at cycle 4.
REQ-020 b_valid or r_valid arriving outside WRESP/RRESP SHALL be ignored (ready=0).
REQ-021 A non-OKAY resp SHALL be passed through unchanged. The block SHALL NOT retry.

Reset
REQ-022 While rstn=0 at a clock edge, the following SHALL hold from the next cycle.
- state=IDLE.
- req_ready=1.
- aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid = 0.
- rsp_rdata=0, rsp_resp=0, rsp_write=0.
- Acceptance flags cleared.
REQ-023 Reset mid-transaction SHALL abandon the transaction silently. The subordinate SHALL be reset concurrently by the system.

Configuration
REQ-024 Macro AXI4LITE_REQ_MASTER_STATS_EN controls statistics.
- Defined: outputs stat_rd_cnt, stat_wr_cnt and stat_err_cnt (16 bits each) SHALL be present.
  - They SHALL increment on rsp fire of a read, of a write, and of resp!=2'b00 respectively.
  - They SHALL saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Zero-wait write: addr=0x40, wdata=0x1122334455667788, strb=0xFF, aw/w/b ready=1 -> aw/w valid at cycle 1 only, rsp_valid at cycle 3, rsp_write=1, rsp_resp=0.
REQ-026 AW before W: aw_ready=1 at cycle 1, w_ready held 0 until cycle 4 -> aw_valid low from cycle 2, w_valid high through cycle 4, b_ready first at cycle 5.
REQ-027 Read with back-pressure: ar_ready=0 for 3 cycles, r_data=0xDEADBEEFCAFEF00D, resp=2'b10, rsp_ready=0 for 2 cycles -> ar_addr stable while waiting, rsp_rdata/rsp_resp held until fire, rsp_resp=2'b10.
REQ-028 Reset asserted in RRESP -> next cycle all valids/readies per REQ-022. A stray r_valid after reset -> r_ready=0 and no response is generated.
REQ-029 Back-to-back write then read against a loopback SRAM subordinate (same address 0x80, data 0xA5A5...) -> read returns 0xA5A5A5A5A5A5A5A5, and req_ready is low throughout each transaction.
REQ-030 STATS_EN defined: 3 reads, 2 writes, 1 SLVERR -> stat_rd_cnt=3, stat_wr_cnt=2, stat_err_cnt=1. Preloaded near-max run -> counts saturate at 0xFFFF.

Source files
------------

// File: rtl/axi4lite_req_master.sv
// Single-outstanding AXI4-Lite manager that turns client requests into AXI transactions.
// Optional statistics counters: define AXI4LITE_REQ_MASTER_STATS_EN.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 64
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 8
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

module axi4lite_req_master (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [`AXI4_ADDR_BITS-1:0] req_addr,
    input  logic [`AXI4_DATA_BITS-1:0] req_wdata,
    input  logic [`AXI4_STRB_BITS-1:0] req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [`AXI4_DATA_BITS-1:0] rsp_rdata,
    output logic [`AXI4_RESP_BITS-1:0] rsp_resp,
    output logic                       m_axi4lite_aw_valid,
    input  logic                       m_axi4lite_aw_ready,
    output logic [`AXI4_ADDR_BITS-1:0] m_axi4lite_aw_addr,
    output logic [2:0]                 m_axi4lite_aw_prot,
    output logic                       m_axi4lite_w_valid,
    input  logic                       m_axi4lite_w_ready,
    output logic [`AXI4_DATA_BITS-1:0] m_axi4lite_w_data,
    output logic [`AXI4_STRB_BITS-1:0] m_axi4lite_w_strb,
    input  logic                       m_axi4lite_b_valid,
    output logic                       m_axi4lite_b_ready,
    input  logic [`AXI4_RESP_BITS-1:0] m_axi4lite_b_resp,
    output logic                       m_axi4lite_ar_valid,
    input  logic                       m_axi4lite_ar_ready,
    output logic [`AXI4_ADDR_BITS-1:0] m_axi4lite_ar_addr,
    output logic [2:0]                 m_axi4lite_ar_prot,
    input  logic                       m_axi4lite_r_valid,
    output logic                       m_axi4lite_r_ready,
    input  logic [`AXI4_DATA_BITS-1:0] m_axi4lite_r_data,
    input  logic [`AXI4_RESP_BITS-1:0] m_axi4lite_r_resp
`ifdef AXI4LITE_REQ_MASTER_STATS_EN
    ,
    output logic [15:0]                stat_rd_cnt,
    output logic [15:0]                stat_wr_cnt,
    output logic [15:0]                stat_err_cnt
`endif
);

    localparam int unsigned ADDR_W = `AXI4_ADDR_BITS;
    localparam int unsigned DATA_W = `AXI4_DATA_BITS;
    localparam int unsigned STRB_W = `AXI4_STRB_BITS;
    localparam int unsigned RESP_W = `AXI4_RESP_BITS;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, DONE} state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                ar_valid_q, ar_valid_d;
    logic                b_ready_q, b_ready_d, r_ready_q, r_ready_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [RESP_W-1:0]   rsp_resp_q, rsp_resp_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                write_q, write_d;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;

    assign aw_fire  = aw_valid_q & m_axi4lite_aw_ready;
    assign w_fire   = w_valid_q & m_axi4lite_w_ready;
    assign b_fire   = b_ready_q & m_axi4lite_b_valid;
    assign ar_fire  = ar_valid_q & m_axi4lite_ar_ready;
    assign r_fire   = r_ready_q & m_axi4lite_r_valid;
    assign rsp_fire = rsp_valid_q & rsp_ready;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_valid_d  = ar_valid_q;
        b_ready_d   = b_ready_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    write_d     = req_write;
                    req_ready_d = 1'b0;
                    if (req_write) begin
                        state_d    = WRITE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            // AW and W may be accepted in either order or together
            WRITE: begin
                if (aw_fire) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_fire) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d   = WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_ready_d = 1'b1;
                end
            end
            WRESP: begin
                if (b_fire) begin
                    state_d     = DONE;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi4lite_b_resp;
                end
            end
            READ: begin
                if (ar_fire) begin
                    state_d    = RRESP;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RRESP: begin
                if (r_fire) begin
                    state_d     = DONE;
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi4lite_r_data;
                    rsp_resp_d  = m_axi4lite_r_resp;
                end
            end
            DONE: begin
                if (rsp_fire) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                ar_valid_d  = 1'b0;
                b_ready_d   = 1'b0;
                r_ready_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
        end
    end

    assign req_ready           = req_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_write           = rsp_write_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_resp            = rsp_resp_q;
    assign m_axi4lite_aw_valid = aw_valid_q;
    assign m_axi4lite_aw_addr  = addr_q;
    assign m_axi4lite_aw_prot  = 3'b000;
    assign m_axi4lite_w_valid  = w_valid_q;
    assign m_axi4lite_w_data   = wdata_q;
    assign m_axi4lite_w_strb   = wstrb_q;
    assign m_axi4lite_b_ready  = b_ready_q;
    assign m_axi4lite_ar_valid = ar_valid_q;
    assign m_axi4lite_ar_addr  = addr_q;
    assign m_axi4lite_ar_prot  = 3'b000;
    assign m_axi4lite_r_ready  = r_ready_q;

`ifdef AXI4LITE_REQ_MASTER_STATS_EN
    logic [15:0] stat_rd_cnt_q, stat_rd_cnt_d;
    logic [15:0] stat_wr_cnt_q, stat_wr_cnt_d;
    logic [15:0] stat_err_cnt_q, stat_err_cnt_d;

    // Saturating counters, bumped when the client accepts a response
    always_comb begin
        stat_rd_cnt_d  = stat_rd_cnt_q;
        stat_wr_cnt_d  = stat_wr_cnt_q;
        stat_err_cnt_d = stat_err_cnt_q;
        if (rsp_fire) begin
            if (!rsp_write_q && stat_rd_cnt_q != 16'hFFFF)
                stat_rd_cnt_d = stat_rd_cnt_q + 16'd1;
            if (rsp_write_q && stat_wr_cnt_q != 16'hFFFF)
                stat_wr_cnt_d = stat_wr_cnt_q + 16'd1;
            if (rsp_resp_q != '0 && stat_err_cnt_q != 16'hFFFF)
                stat_err_cnt_d = stat_err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_rd_cnt_q  <= '0;
            stat_wr_cnt_q  <= '0;
            stat_err_cnt_q <= '0;
        end else begin
            stat_rd_cnt_q  <= stat_rd_cnt_d;
            stat_wr_cnt_q  <= stat_wr_cnt_d;
            stat_err_cnt_q <= stat_err_cnt_d;
        end
    end

    assign stat_rd_cnt  = stat_rd_cnt_q;
    assign stat_wr_cnt  = stat_wr_cnt_q;
    assign stat_err_cnt = stat_err_cnt_q;
`endif

endmodule

// File: tb/tb_axi4lite_req_master.sv
// Directed self-checking bench for axi4lite_req_master (cycle-accurate handshake checks).
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 64
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 8
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

module tb_axi4lite_req_master;

    localparam int unsigned ADDR_W = `AXI4_ADDR_BITS;
    localparam int unsigned DATA_W = `AXI4_DATA_BITS;
    localparam int unsigned STRB_W = `AXI4_STRB_BITS;
    localparam int unsigned RESP_W = `AXI4_RESP_BITS;

    logic              clk;
    logic              rstn;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [RESP_W-1:0] rsp_resp;
    logic              aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic              ar_valid, ar_ready, r_valid, r_ready;
    logic [ADDR_W-1:0] aw_addr, ar_addr;
    logic [2:0]        aw_prot, ar_prot;
    logic [DATA_W-1:0] w_data, r_data;
    logic [STRB_W-1:0] w_strb;
    logic [RESP_W-1:0] b_resp, r_resp;
`ifdef AXI4LITE_REQ_MASTER_STATS_EN
    logic [15:0]       stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    axi4lite_req_master dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi4lite_aw_valid(aw_valid), .m_axi4lite_aw_ready(aw_ready),
        .m_axi4lite_aw_addr(aw_addr), .m_axi4lite_aw_prot(aw_prot),
        .m_axi4lite_w_valid(w_valid), .m_axi4lite_w_ready(w_ready),
        .m_axi4lite_w_data(w_data), .m_axi4lite_w_strb(w_strb),
        .m_axi4lite_b_valid(b_valid), .m_axi4lite_b_ready(b_ready),
        .m_axi4lite_b_resp(b_resp),
        .m_axi4lite_ar_valid(ar_valid), .m_axi4lite_ar_ready(ar_ready),
        .m_axi4lite_ar_addr(ar_addr), .m_axi4lite_ar_prot(ar_prot),
        .m_axi4lite_r_valid(r_valid), .m_axi4lite_r_ready(r_ready),
        .m_axi4lite_r_data(r_data), .m_axi4lite_r_resp(r_resp)
`ifdef AXI4LITE_REQ_MASTER_STATS_EN
        ,
        .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Cycle n is the interval just after the n-th rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_sub;
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
        b_resp = '0; r_resp = '0; r_data = '0; rsp_ready = 0;
    endtask

    task automatic start_req(input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    endtask

    // Zero-wait loopback subordinate and client; returns response and latency to rsp_valid
    task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [RESP_W-1:0] resp, output logic [DATA_W-1:0] rd,
                           output logic [RESP_W-1:0] rr, output logic rw, output int lat,
                           output logic busy_ok);
        start_req(wr, a, d, '1);
        aw_ready = 1; w_ready = 1; ar_ready = 1;
        b_valid = 1; b_resp = resp; r_valid = 1; r_resp = resp;
        r_data = mem.exists(a) ? mem[a] : '0;
        rsp_ready = 1;
        busy_ok = 1;
        tick;
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (aw_valid && w_valid) mem[aw_addr] = w_data;
            if (req_ready) busy_ok = 0;
            tick;
            lat++;
        end
        if (req_ready) busy_ok = 0;
        rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
        tick;
        idle_sub;
    endtask

    logic [DATA_W-1:0] t_rd;
    logic [RESP_W-1:0] t_rr;
    logic              t_rw, t_busy;
    int                t_lat;

    initial begin
        rstn = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        idle_sub;
        tick; tick;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_valids", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}), 64'd0);
        chk("rst_rsp", 64'({rsp_write, rsp_resp}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        rstn = 1;
        tick;

        // Zero-wait write; b_valid presented early must be ignored until WRESP
        start_req(1, 32'h40, 64'h1122334455667788, 8'hFF);
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
        tick;
        req_valid = 0;
        chk("w1_c1_valids", 64'({aw_valid, w_valid, req_ready, b_ready}), 64'b1100);
        chk("w1_aw_addr", 64'(aw_addr), 64'h40);
        chk("w1_w_data", 64'(w_data), 64'h1122334455667788);
        chk("w1_w_strb", 64'(w_strb), 64'hFF);
        chk("w1_prot", 64'({aw_prot, ar_prot}), 64'd0);
        tick;
        chk("w1_c2", 64'({aw_valid, w_valid, b_ready, rsp_valid}), 64'b0010);
        rsp_ready = 1;
        tick;
        b_valid = 0;
        chk("w1_c3_rsp", 64'({rsp_valid, rsp_write, b_ready}), 64'b110);
        chk("w1_c3_resp", 64'(rsp_resp), 64'd0);
        tick;
        chk("w1_c4", 64'({req_ready, rsp_valid}), 64'b10);
        idle_sub;

        // Read with AR back-pressure, SLVERR and response back-pressure
        start_req(0, 32'h100, 64'h0, 8'h0);
        tick;
        req_valid = 0;
        chk("r_c1", 64'({ar_valid, aw_valid, w_valid, r_ready}), 64'b1000);
        chk("r_c1_addr", 64'(ar_addr), 64'h100);
        tick;
        chk("r_c2_addr", 64'({31'd0, ar_valid, ar_addr}), 64'h1_0000_0100);
        tick;
        chk("r_c3_addr", 64'({31'd0, ar_valid, ar_addr}), 64'h1_0000_0100);
        r_valid = 1; r_data = 64'h1111; r_resp = 2'b00;
        tick;
        chk("r_c4_wait", 64'({ar_valid, r_ready, rsp_valid}), 64'b100);
        ar_ready = 1; r_valid = 0;
        tick;
        ar_ready = 0;
        chk("r_c5", 64'({ar_valid, r_ready}), 64'b01);
        r_valid = 1; r_data = 64'hDEADBEEFCAFEF00D; r_resp = 2'b10;
        tick;
        r_valid = 0; r_data = '0; r_resp = '0;
        chk("r_c6_ctl", 64'({rsp_valid, rsp_write, r_ready}), 64'b100);
        chk("r_c6_data", 64'(rsp_rdata), 64'hDEADBEEFCAFEF00D);
        chk("r_c6_resp", 64'(rsp_resp), 64'd2);
        tick;
        chk("r_c7_hold", 64'(rsp_rdata), 64'hDEADBEEFCAFEF00D);
        chk("r_c7_ctl", 64'({rsp_valid, rsp_resp, req_ready}), 64'b1100);
        tick;
        chk("r_c8_hold", 64'({rsp_valid, rsp_resp}), 64'b110);
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
        chk("r_c9", 64'({req_ready, rsp_valid}), 64'b10);

        // Write with AW accepted first and W delayed to cycle 4
        start_req(1, 32'h48, 64'h0102030405060708, 8'h0F);
        aw_ready = 1;
        tick;
        req_valid = 0;
        chk("aw_c1", 64'({aw_valid, w_valid}), 64'b11);
        tick;
        aw_ready = 0;
        chk("aw_c2", 64'({aw_valid, w_valid, b_ready}), 64'b010);
        tick;
        chk("aw_c3", 64'({aw_valid, w_valid, b_ready}), 64'b010);
        chk("aw_c3_data", 64'(w_data), 64'h0102030405060708);
        tick;
        chk("aw_c4", 64'({w_valid, b_ready}), 64'b10);
        w_ready = 1;
        tick;
        w_ready = 0;
        chk("aw_c5", 64'({aw_valid, w_valid, b_ready}), 64'b001);
        chk("aw_c5_strb", 64'(w_strb), 64'h0F);
        b_valid = 1; b_resp = 2'b00; rsp_ready = 1;
        tick;
        b_valid = 0;
        chk("aw_c6_rsp", 64'({rsp_valid, rsp_write, rsp_resp}), 64'b1100);
        chk("aw_c6_rdata_zero", 64'(rsp_rdata), 64'd0);
        tick;
        chk("aw_c7", 64'(req_ready), 64'd1);
        idle_sub;

        // Reset while in RRESP abandons the read; a late r_valid is ignored
        start_req(0, 32'h10, 64'h0, 8'h0);
        ar_ready = 1;
        tick;
        req_valid = 0;
        tick;
        ar_ready = 0;
        chk("rr_c2_rready", 64'(r_ready), 64'd1);
        rstn = 0;
        tick;
        rstn = 1;
        chk("rr_after_rst", 64'({req_ready, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}),
            64'b1000000);
        r_valid = 1; r_data = 64'h5555; r_resp = 2'b00; rsp_ready = 1;
        tick;
        chk("rr_stray", 64'({r_ready, rsp_valid, req_ready}), 64'b001);
        tick;
        chk("rr_stray2", 64'({r_ready, rsp_valid}), 64'b00);
        idle_sub;

        // Back-to-back write then read through the loopback subordinate
        run_txn(1, 32'h80, 64'hA5A5A5A5A5A5A5A5, 2'b00, t_rd, t_rr, t_rw, t_lat, t_busy);
        chk("lb_w_lat", 64'(t_lat), 64'd3);
        chk("lb_w_rsp", 64'({t_rw, t_rr}), 64'b100);
        chk("lb_w_busy", 64'(t_busy), 64'd1);
        chk("lb_w_ready_back", 64'(req_ready), 64'd1);
        run_txn(0, 32'h80, 64'h0, 2'b00, t_rd, t_rr, t_rw, t_lat, t_busy);
        chk("lb_r_lat", 64'(t_lat), 64'd3);
        chk("lb_r_data", 64'(t_rd), 64'hA5A5A5A5A5A5A5A5);
        chk("lb_r_rsp", 64'({t_rw, t_rr}), 64'b000);
        chk("lb_r_busy", 64'(t_busy), 64'd1);

`ifdef AXI4LITE_REQ_MASTER_STATS_EN
        rstn = 0;
        tick;
        rstn = 1;
        chk("st_rst", 64'({stat_rd_cnt, stat_wr_cnt, stat_err_cnt}), 64'd0);
        for (int i = 0; i < 3; i++)
            run_txn(0, 32'h80, 64'h0, 2'b00, t_rd, t_rr, t_rw, t_lat, t_busy);
        run_txn(1, 32'h90, 64'h1, 2'b00, t_rd, t_rr, t_rw, t_lat, t_busy);
        run_txn(1, 32'h98, 64'h2, 2'b10, t_rd, t_rr, t_rw, t_lat, t_busy);
        chk("st_rd", 64'(stat_rd_cnt), 64'd3);
        chk("st_wr", 64'(stat_wr_cnt), 64'd2);
        chk("st_err", 64'(stat_err_cnt), 64'd1);
        force dut.stat_wr_cnt_q = 16'hFFFE;
        #1;
        release dut.stat_wr_cnt_q;
        run_txn(1, 32'h90, 64'h3, 2'b00, t_rd, t_rr, t_rw, t_lat, t_busy);
        chk("st_wr_fffe", 64'(stat_wr_cnt), 64'hFFFF);
        run_txn(1, 32'h90, 64'h4, 2'b00, t_rd, t_rr, t_rw, t_lat, t_busy);
        chk("st_wr_sat", 64'(stat_wr_cnt), 64'hFFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
